// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: scoreboard slot, FSM states
// and register-address constants.
package pipe_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dest;
        logic                  wb_en;
        logic                  mem_r;
        logic                  mem_w;
    } sb_slot_t;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage instruction info and memory status in, pipeline hold/flush controls out.
interface pipe_hazard_ctrl_if
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_src1;
    logic [REG_ADDR_W-1:0] id_src2;
    logic                  id_two_src;
    logic [REG_ADDR_W-1:0] id_dest;
    logic                  id_wb_en;
    logic                  id_mem_r_en;
    logic                  id_mem_w_en;
    logic                  br_taken;
    logic                  mem_ready;

    logic                  pc_hold;
    logic                  ifid_hold;
    logic                  idex_bubble;
    logic                  if_flush;
    logic                  pipe_freeze;
    logic                  mem_err;
    logic [CNT_W-1:0]      stall_cnt;

    modport master (
        output id_valid, id_src1, id_src2, id_two_src, id_dest, id_wb_en,
               id_mem_r_en, id_mem_w_en, br_taken, mem_ready,
        input  pc_hold, ifid_hold, idex_bubble, if_flush, pipe_freeze,
               mem_err, stall_cnt
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_two_src, id_dest, id_wb_en,
               id_mem_r_en, id_mem_w_en, br_taken, mem_ready,
        output pc_hold, ifid_hold, idex_bubble, if_flush, pipe_freeze,
               mem_err, stall_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_sb_hit_cmp.sv
// One scoreboard slot versus one ID source register: does the slot produce it?
module sb_hit_cmp
    import pipe_pkg::*;
#(
    parameter bit ZERO_REG_EN = 1'b1
) (
    input  sb_slot_t              slot,
    input  logic [REG_ADDR_W-1:0] src,
    output logic                  hit
);

    assign hit = slot.valid && slot.wb_en && (slot.dest == src) &&
                 !(ZERO_REG_EN && (src == ZERO_REG));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing: RAW-hazard bubbles from an EXE/MEM shadow scoreboard,
// taken-branch IF flush, and whole-pipe freeze while data memory is busy.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter bit FWD_EN      = 1'b0,
    parameter bit ZERO_REG_EN = 1'b1,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(MEM_TIMEOUT);

    sb_slot_t                    exe_q, mem_q, id_ent;
    sb_slot_t [1:0]              slots;
    logic [1:0][REG_ADDR_W-1:0]  srcs;
    logic [1:0][1:0]             hit;
    logic                        exe_hit, mem_hit, hazard, mem_stall, freeze;
    state_t                      state;
    logic [TMO_W-1:0]            tmo_cnt;
    logic                        mem_err_q;
    logic [CNT_W-1:0]            stall_q;

    assign slots = {mem_q, exe_q};
    assign srcs  = {bus.id_src2, bus.id_src1};

    for (genvar s = 0; s < 2; s++) begin : g_slot
        for (genvar r = 0; r < 2; r++) begin : g_src
            sb_hit_cmp #(.ZERO_REG_EN(ZERO_REG_EN)) u_cmp (
                .slot (slots[s]),
                .src  (srcs[r]),
                .hit  (hit[s][r])
            );
        end
    end

    assign exe_hit = hit[0][0] || (bus.id_two_src && hit[0][1]);
    assign mem_hit = hit[1][0] || (bus.id_two_src && hit[1][1]);

    // With forwarding only a load still in EXE cannot supply its result in time.
    assign hazard    = bus.id_valid && (FWD_EN ? (exe_hit && exe_q.mem_r) : (exe_hit || mem_hit));
    assign mem_stall = mem_q.valid && (mem_q.mem_r || mem_q.mem_w) && !bus.mem_ready;
    assign freeze    = (state == RUN) ? mem_stall : !bus.mem_ready;

    assign bus.pc_hold     = hazard || freeze;
    assign bus.ifid_hold   = hazard || freeze;
    assign bus.idex_bubble = hazard && !freeze;
    assign bus.if_flush    = bus.br_taken && bus.id_valid && !hazard && !freeze;
    assign bus.pipe_freeze = freeze;
    assign bus.mem_err     = mem_err_q;
    assign bus.stall_cnt   = stall_q;

    always_comb begin
        id_ent = '0;
        if (bus.id_valid && !bus.idex_bubble) begin
            id_ent.valid = 1'b1;
            id_ent.dest  = bus.id_dest;
            id_ent.wb_en = bus.id_wb_en;
            id_ent.mem_r = bus.id_mem_r_en;
            id_ent.mem_w = bus.id_mem_w_en;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            exe_q   <= '0;
            mem_q   <= '0;
            stall_q <= '0;
        end else begin
            if (!freeze) begin
                mem_q <= exe_q;
                exe_q <= id_ent;
            end
            if (bus.pc_hold && (stall_q != '1))
                stall_q <= stall_q + 1'b1;
        end
    end

    // Timeout only flags the condition; the pipe keeps waiting for mem_ready.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= RUN;
            tmo_cnt   <= '0;
            mem_err_q <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        state   <= MEM_WAIT;
                        tmo_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (tmo_cnt != TMO_MAX) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (tmo_cnt == TMO_MAX - 1'b1)
                            mem_err_q <= 1'b1;
                    end
                    if (bus.mem_ready)
                        state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a forwarding and a non-forwarding instance share
// stimulus; an instruction-level model checks both every cycle.
module tb_pipe_hazard_ctrl;

    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       i_valid, i_two, i_wb, i_mr, i_mw, i_br, i_mrdy;
    logic [4:0] i_src1, i_src2, i_dest;

    pipe_hazard_ctrl_if #(.CNT_W(16)) ifa ();
    pipe_hazard_ctrl_if #(.CNT_W(4))  ifb ();

    assign ifa.id_valid = i_valid;   assign ifb.id_valid = i_valid;
    assign ifa.id_src1 = i_src1;     assign ifb.id_src1 = i_src1;
    assign ifa.id_src2 = i_src2;     assign ifb.id_src2 = i_src2;
    assign ifa.id_two_src = i_two;   assign ifb.id_two_src = i_two;
    assign ifa.id_dest = i_dest;     assign ifb.id_dest = i_dest;
    assign ifa.id_wb_en = i_wb;      assign ifb.id_wb_en = i_wb;
    assign ifa.id_mem_r_en = i_mr;   assign ifb.id_mem_r_en = i_mr;
    assign ifa.id_mem_w_en = i_mw;   assign ifb.id_mem_w_en = i_mw;
    assign ifa.br_taken = i_br;      assign ifb.br_taken = i_br;
    assign ifa.mem_ready = i_mrdy;   assign ifb.mem_ready = i_mrdy;

    pipe_hazard_ctrl #(.FWD_EN(1'b1), .ZERO_REG_EN(1'b1), .MEM_TIMEOUT(TMO), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa));
    pipe_hazard_ctrl #(.FWD_EN(1'b0), .ZERO_REG_EN(1'b1), .MEM_TIMEOUT(TMO), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb));

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the instructions sitting in EXE [0] and MEM [1] for each instance.
    typedef struct { bit v; int dest; bit wb; bit mr; bit mw; } ent_t;
    ent_t sb [2][2];
    bit   m_wait [2];
    int   m_wcnt [2];
    bit   m_err  [2];
    int   m_scnt [2];
    int   fwd    [2] = '{1, 0};
    int   smax   [2] = '{65535, 15};
    bit   e_frz [2], e_haz [2], e_hold [2], e_bub [2], e_fl [2];

    function automatic bit produces_src(ent_t e);
        if (!e.v || !e.wb) return 0;
        if (i_src1 != 0 && e.dest == int'(i_src1)) return 1;
        if (i_two && i_src2 != 0 && e.dest == int'(i_src2)) return 1;
        return 0;
    endfunction

    task automatic cmp_all(int k, logic hold, logic ifid, logic bub, logic fl,
                           logic frz, logic err, int sc);
        chk($sformatf("pc_hold_%0d", k), hold, e_hold[k]);
        chk($sformatf("ifid_hold_%0d", k), ifid, e_hold[k]);
        chk($sformatf("idex_bubble_%0d", k), bub, e_bub[k]);
        chk($sformatf("if_flush_%0d", k), fl, e_fl[k]);
        chk($sformatf("pipe_freeze_%0d", k), frz, e_frz[k]);
        chk($sformatf("mem_err_%0d", k), err, m_err[k]);
        chk($sformatf("stall_cnt_%0d", k), sc, m_scnt[k]);
    endtask

    always begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            e_frz[k] = m_wait[k] ? !i_mrdy
                                 : (sb[k][1].v && (sb[k][1].mr || sb[k][1].mw) && !i_mrdy);
            if (fwd[k] != 0) e_haz[k] = i_valid && produces_src(sb[k][0]) && sb[k][0].mr;
            else             e_haz[k] = i_valid && (produces_src(sb[k][0]) || produces_src(sb[k][1]));
            e_hold[k] = e_haz[k] || e_frz[k];
            e_bub[k]  = e_haz[k] && !e_frz[k];
            e_fl[k]   = i_br && i_valid && !e_haz[k] && !e_frz[k];
        end
        if (chk_en) begin
            cmp_all(0, ifa.pc_hold, ifa.ifid_hold, ifa.idex_bubble, ifa.if_flush,
                    ifa.pipe_freeze, ifa.mem_err, int'(ifa.stall_cnt));
            cmp_all(1, ifb.pc_hold, ifb.ifid_hold, ifb.idex_bubble, ifb.if_flush,
                    ifb.pipe_freeze, ifb.mem_err, int'(ifb.stall_cnt));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                sb[k][0] = '{0, 0, 0, 0, 0};
                sb[k][1] = '{0, 0, 0, 0, 0};
                m_wait[k] = 0; m_wcnt[k] = 0; m_err[k] = 0; m_scnt[k] = 0;
            end else begin
                if (e_hold[k] && m_scnt[k] < smax[k]) m_scnt[k]++;
                if (m_wait[k]) begin
                    if (m_wcnt[k] < TMO) begin
                        m_wcnt[k]++;
                        if (m_wcnt[k] == TMO) m_err[k] = 1;
                    end
                    if (i_mrdy) m_wait[k] = 0;
                end else if (e_frz[k]) begin
                    m_wait[k] = 1;
                    m_wcnt[k] = 0;
                end
                if (!e_frz[k]) begin
                    sb[k][1] = sb[k][0];
                    if (i_valid && !e_bub[k])
                        sb[k][0] = '{1, int'(i_dest), i_wb, i_mr, i_mw};
                    else
                        sb[k][0] = '{0, 0, 0, 0, 0};
                end
            end
        end
    end

    task automatic set_in(bit v, int s1, int s2, bit two, int d, bit wb, bit mr, bit mw,
                          bit br, bit mrdy);
        i_valid = v; i_src1 = 5'(s1); i_src2 = 5'(s2); i_two = two; i_dest = 5'(d);
        i_wb = wb; i_mr = mr; i_mw = mw; i_br = br; i_mrdy = mrdy;
    endtask

    // Apply one cycle of ID inputs; returns mid-cycle with outputs settled.
    task automatic drive(bit v, int s1, int s2, bit two, int d, bit wb, bit mr, bit mw,
                         bit br, bit mrdy);
        @(posedge clk); #1;
        set_in(v, s1, s2, two, d, wb, mr, mw, br, mrdy);
        @(negedge clk);
    endtask

    task automatic idle(bit mrdy);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, mrdy);
    endtask

    task automatic do_reset(bit mrdy);
        @(posedge clk); #1;
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, mrdy);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic chk_idle(string tag);
        chk({tag, "_hold_a"}, ifa.pc_hold, 0);
        chk({tag, "_bub_a"}, ifa.idex_bubble, 0);
        chk({tag, "_flush_a"}, ifa.if_flush, 0);
        chk({tag, "_frz_a"}, ifa.pipe_freeze, 0);
        chk({tag, "_err_a"}, ifa.mem_err, 0);
        chk({tag, "_cnt_a"}, int'(ifa.stall_cnt), 0);
        chk({tag, "_frz_b"}, ifb.pipe_freeze, 0);
        chk({tag, "_cnt_b"}, int'(ifb.stall_cnt), 0);
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        do_reset(1);
        chk_en = 1;
        chk_idle("rst");

        // Load-use: LD r3 then ADD r5,r3,r4
        drive(1, 0, 0, 0, 3, 1, 1, 0, 0, 1);
        chk("lu_c1_hold_a", ifa.pc_hold, 0);
        drive(1, 3, 4, 1, 5, 1, 0, 0, 0, 1);
        chk("lu_c2_hold_a", ifa.pc_hold, 1);
        chk("lu_c2_ifid_a", ifa.ifid_hold, 1);
        chk("lu_c2_bub_a", ifa.idex_bubble, 1);
        drive(1, 3, 4, 1, 5, 1, 0, 0, 0, 1);
        chk("lu_c3_hold_a", ifa.pc_hold, 0);
        chk("lu_c3_cnt_a", int'(ifa.stall_cnt), 1);
        chk("lu_c3_hold_b", ifb.pc_hold, 1);

        // RAW without forwarding: ADD r2 then SUB r6,r2,r1
        do_reset(1);
        drive(1, 0, 0, 0, 2, 1, 0, 0, 0, 1);
        drive(1, 2, 1, 1, 6, 1, 0, 0, 0, 1);
        chk("raw_c2_hold_b", ifb.pc_hold, 1);
        chk("raw_c2_bub_b", ifb.idex_bubble, 1);
        chk("raw_c2_hold_a", ifa.pc_hold, 0);
        drive(1, 2, 1, 1, 6, 1, 0, 0, 0, 1);
        chk("raw_c3_hold_b", ifb.pc_hold, 1);
        chk("raw_c3_bub_b", ifb.idex_bubble, 1);
        drive(1, 2, 1, 1, 6, 1, 0, 0, 0, 1);
        chk("raw_c4_hold_b", ifb.pc_hold, 0);
        chk("raw_c4_cnt_b", int'(ifb.stall_cnt), 2);
        drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        drive(1, 0, 1, 1, 6, 1, 0, 0, 0, 1);
        chk("r0_c1_hold_b", ifb.pc_hold, 0);
        drive(1, 0, 1, 1, 6, 1, 0, 0, 0, 1);
        chk("r0_c2_hold_b", ifb.pc_hold, 0);
        chk("r0_cnt_b", int'(ifb.stall_cnt), 2);

        // Branch: plain taken, then taken while a load-use stall is active
        do_reset(1);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("br_flush_a", ifa.if_flush, 1);
        chk("br_flush_b", ifb.if_flush, 1);
        idle(1);
        chk("br_idle_flush_a", ifa.if_flush, 0);
        drive(1, 0, 0, 0, 7, 1, 1, 0, 0, 1);
        drive(1, 7, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("brlu_c1_flush_a", ifa.if_flush, 0);
        chk("brlu_c1_hold_a", ifa.pc_hold, 1);
        drive(1, 7, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("brlu_c2_flush_a", ifa.if_flush, 1);

        // Memory wait: store in MEM, LD r9 in EXE, ADD r1,r9 waiting in ID
        do_reset(1);
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        drive(1, 0, 0, 0, 9, 1, 1, 0, 0, 1);
        for (int c = 0; c < 3; c++) begin
            drive(1, 9, 0, 0, 1, 1, 0, 0, 0, 0);
            chk("mw_frz_a", ifa.pipe_freeze, 1);
            chk("mw_hold_a", ifa.pc_hold, 1);
            chk("mw_bub_a", ifa.idex_bubble, 0);
            chk("mw_frz_b", ifb.pipe_freeze, 1);
        end
        drive(1, 9, 0, 0, 1, 1, 0, 0, 0, 1);
        chk("mw_rel_frz_a", ifa.pipe_freeze, 0);
        chk("mw_rel_bub_a", ifa.idex_bubble, 1);
        drive(1, 9, 0, 0, 1, 1, 0, 0, 0, 1);
        chk("mw_after_frz_a", ifa.pipe_freeze, 0);
        chk("mw_after_hold_a", ifa.pc_hold, 0);
        chk("mw_cnt_a", int'(ifa.stall_cnt), 4);

        // Timeout: 10 cycles of mem_ready low with a store in MEM
        do_reset(1);
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        idle(1);
        for (int w = 1; w <= 10; w++) begin
            idle(0);
            chk("to_frz_a", ifa.pipe_freeze, 1);
            if (w == 5) chk("to_err_pre_a", ifa.mem_err, 0);
            if (w == 6) begin
                chk("to_err_a", ifa.mem_err, 1);
                chk("to_err_b", ifb.mem_err, 1);
            end
        end
        idle(1);
        chk("to_rel_frz_a", ifa.pipe_freeze, 0);
        chk("to_rel_err_a", ifa.mem_err, 1);

        // Reset while frozen in the wait state with mem_err already set
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        idle(1);
        idle(0);
        idle(0);
        idle(0);
        do_reset(0);
        chk_idle("rstw");
        drive(1, 0, 0, 0, 3, 1, 1, 0, 0, 1);
        drive(1, 3, 4, 1, 5, 1, 0, 0, 0, 1);
        chk("rstw_lu_hold_a", ifa.pc_hold, 1);
        chk("rstw_lu_bub_a", ifa.idex_bubble, 1);

        // Randomized traffic, small register range to provoke hits
        for (int n = 0; n < 4000; n++) begin
            @(posedge clk); #1;
            rst = ($urandom % 300) != 0;
            set_in(($urandom % 5) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom % 2, $urandom_range(0, 3), ($urandom % 4) != 0,
                   ($urandom % 3) == 0, ($urandom % 4) == 0, ($urandom % 6) == 0,
                   ((n / 250) % 2 == 0) ? (($urandom % 10) < 7) : (($urandom % 10) < 3));
        end
        @(posedge clk); #1;
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage core. It keeps a shadow scoreboard of the instructions in EXE and MEM, detects RAW hazards against the instruction currently in ID, and inserts bubbles. It also converts an ID-stage taken branch into an IF flush and freezes the whole pipe while the data memory is not ready. It sits beside ID_Stage and drives the hold/flush controls of the IF, IF/ID and ID/EXE registers.

Parameters:
FWD_EN, 0, 1 = forwarding unit present; stall only on load-use. 0 = stall on any RAW with EXE or MEM.
ZERO_REG_EN, 1, 1 = register 0 is hardwired zero and never causes a hazard.
MEM_TIMEOUT, 255, number of MEM_WAIT cycles after which mem_err is set.
CNT_W, 16, width of the stall-cycle counter.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous reset, active-low.
id_valid  in  1  ID holds a real instruction.
id_src1  in  5  ID source register 1.
id_src2  in  5  ID source register 2.
id_two_src  in  1  ID instruction reads src2.
id_dest  in  5  ID destination register.
id_wb_en  in  1  ID instruction writes back.
id_mem_r_en  in  1  ID instruction is a load.
id_mem_w_en  in  1  ID instruction is a store.
br_taken  in  1  ID resolved a taken branch.
mem_ready  in  1  data memory done for the op currently in MEM.
pc_hold  out  1  hold the PC.
ifid_hold  out  1  hold the IF/ID register.
idex_bubble  out  1  load a NOP into ID/EXE.
if_flush  out  1  clear IF/ID.
pipe_freeze  out  1  freeze ID/EXE, EXE/MEM and MEM/WB.
mem_err  out  1  sticky memory timeout flag.
stall_cnt  out  CNT_W  saturating count of stall or freeze cycles.

Behaviour:
- Scoreboard: two slots, EXE and MEM. Each slot holds {valid, dest, wb_en, mem_r, mem_w}.
- Scoreboard update, only when pipe_freeze=0:
  - MEM <= EXE.
  - EXE <= ID entry if id_valid && !idex_bubble; otherwise EXE <= invalid.
- The WB stage is never a hazard: the register file writes before it is read in the same cycle.
- Hit rule: a slot hits a source register when slot.valid && slot.wb_en && slot.dest == src, and not (ZERO_REG_EN && src == 0). src2 is checked only when id_two_src=1.
- hazard, combinational:
  - FWD_EN=1: EXE slot hits and EXE.mem_r=1.
  - FWD_EN=0: EXE or MEM slot hits.
  - Always gated by id_valid.
- FSM states: RUN, MEM_WAIT. Reset state is RUN.
  - RUN: mem_stall = MEM.valid && (MEM.mem_r || MEM.mem_w) && !mem_ready. If mem_stall, pipe_freeze=1 combinationally and next state is MEM_WAIT.
  - MEM_WAIT: pipe_freeze = !mem_ready. When mem_ready=1, freeze drops in that same cycle and next state is RUN.
- Output equations:
  - pc_hold = ifid_hold = hazard || pipe_freeze.
  - idex_bubble = hazard && !pipe_freeze.
  - if_flush = br_taken && id_valid && !hazard && !pipe_freeze.
- Priority: freeze > hazard > branch. A branch seen during a stall is re-evaluated when ID releases; no flush is issued early.
- Timeout counter:
  - Cleared on entry to MEM_WAIT; increments each MEM_WAIT cycle.
  - When it reaches MEM_TIMEOUT, mem_err is set and the counter stops.
  - The pipe keeps waiting; there is no abort.
  - mem_err clears only on reset.
- stall_cnt increments on any cycle with pc_hold=1 and saturates at all-ones.
- Reset (rst=0 at a clock edge) applies mid-operation, including inside MEM_WAIT:
  - Both slots invalid, state RUN, timeout counter 0, mem_err 0, stall_cnt 0.
  - All outputs are 0 on the cycle after reset, given idle inputs.

Decomposition:
- Shared package pipe_pkg holds:
  - the scoreboard slot struct;
  - the FSM state enum {RUN, MEM_WAIT};
  - REG_ADDR_W=5 and the ZERO_REG constant.
- The hit comparator is a natural sub-module, sb_hit_cmp: slot, src and ZERO_REG_EN in, hit out. Instantiate it four times (two slots × two sources).

Test Plan:
- Load-use, FWD_EN=1: LD r3 enters EXE while ID has ADD r5,r3,r4 (two-src) -> pc_hold=ifid_hold=idex_bubble=1 for exactly 1 cycle, then 0; stall_cnt=1.
- RAW without forwarding, FWD_EN=0: ADD r2 followed by SUB r6,r2,r1 -> 2 stall cycles (hit in EXE, then MEM), 2 bubbles, stall_cnt=2. Repeat with dest r0 -> 0 stalls.
- Branch: br_taken=1 with no hazard -> if_flush=1 for 1 cycle. br_taken=1 in a load-use cycle -> if_flush=0 that cycle and 1 on the following cycle.
- Memory wait: store reaches MEM, mem_ready low for 3 cycles -> pipe_freeze=1 for 3 cycles, scoreboard unchanged; mem_ready=1 -> freeze=0 in the same cycle; state RUN.
- Timeout, MEM_TIMEOUT=4: mem_ready held low for 10 cycles -> mem_err rises after the 4th MEM_WAIT cycle, stays 1 after mem_ready returns, freeze still released normally.
- Reset mid-MEM_WAIT with mem_err=1 -> the next cycle shows all outputs 0, stall_cnt=0, and an immediate load-use pair stalls correctly.
